// File: rtl/player_ctrl.sv
// Player cannon controller: movement, fire gating and the life/respawn FSM.
// Advanced once per frame on frame_clk; every output comes straight from a flop.
module player_ctrl #(
    parameter int          X_W            = 10,
    parameter int          X_MIN          = 0,
    parameter int          X_MAX          = 639,
    parameter int          X_CENTER       = 320,
    parameter int          STEP           = 2,
    parameter int          HALF_W         = 8,
    parameter logic [7:0]  KEY_LEFT       = 8'h04,
    parameter logic [7:0]  KEY_RIGHT      = 8'h07,
    parameter logic [7:0]  KEY_FIRE       = 8'h2C,
    parameter int          FIRE_CD        = 16,
    parameter int          LIVES          = 3,
    parameter int          DEATH_FRAMES   = 32,
    parameter int          RESPAWN_FRAMES = 64
) (
    input  logic           frame_clk,
    input  logic           Reset,
    input  logic [7:0]     keycode,
    input  logic           hit,
    input  logic           bullet_busy,
    output logic [X_W-1:0] player_x,
    output logic [X_W-1:0] player_hw,
    output logic           fire,
    output logic [2:0]     lives,
    output logic [1:0]     state_o,
    output logic           blink,
    output logic           game_over
);

    localparam int CNT_MAX = (DEATH_FRAMES > RESPAWN_FRAMES) ? DEATH_FRAMES : RESPAWN_FRAMES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int CDW     = (FIRE_CD > 0) ? $clog2(FIRE_CD + 1) : 1;
    localparam int BB      = (CW > 2) ? 2 : CW - 1;
    localparam int XW1     = X_W + 1;

    // Bounds and step held one bit wider so x-STEP cannot wrap below zero
    localparam logic [XW1-1:0] LO  = XW1'(X_MIN + HALF_W);
    localparam logic [XW1-1:0] HI  = XW1'(X_MAX - HALF_W);
    localparam logic [XW1-1:0] STP = XW1'(STEP);

    typedef enum logic [1:0] {
        ALIVE     = 2'b00,
        DYING     = 2'b01,
        RESPAWN   = 2'b10,
        GAME_OVER = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [2:0]     lives_q, lives_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CDW-1:0] cd_q, cd_d;
    logic [7:0]     prev_q, prev_d;
    logic           fire_q, fire_d;
    logic           blink_q, blink_d;

    logic [XW1-1:0] x_wide;
    logic [XW1-1:0] x_left;
    logic [XW1-1:0] x_right;
    logic           mobile;

    // Next-state: movement, fire edge/cooldown gating and life state machine
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        prev_d  = keycode;
        fire_d  = 1'b0;
        blink_d = 1'b0;

        x_wide  = {1'b0, x_q};
        x_left  = (x_wide < LO + STP) ? LO : x_wide - STP;
        x_right = (x_wide + STP > HI) ? HI : x_wide + STP;

        // A hit in ALIVE wins the frame: no move, no shot
        mobile = ((state_q == ALIVE) && !hit) || (state_q == RESPAWN);

        if (mobile) begin
            if (keycode == KEY_LEFT)
                x_d = x_left[X_W-1:0];
            else if (keycode == KEY_RIGHT)
                x_d = x_right[X_W-1:0];
        end

        fire_d = mobile && (keycode == KEY_FIRE) && (prev_q != KEY_FIRE)
                 && (cd_q == '0) && !bullet_busy;

        if (fire_d)
            cd_d = CDW'(FIRE_CD);
        else if (cd_q != '0)
            cd_d = cd_q - CDW'(1);
        else
            cd_d = cd_q;

        unique case (state_q)
            ALIVE: begin
                if (hit) begin
                    cnt_d = '0;
                    if (lives_q <= 3'd1) begin
                        lives_d = 3'd0;
                        state_d = GAME_OVER;
                    end else begin
                        lives_d = lives_q - 3'd1;
                        state_d = DYING;
                    end
                end
            end
            DYING: begin
                if (cnt_q == CW'(DEATH_FRAMES - 1)) begin
                    state_d = RESPAWN;
                    x_d     = X_W'(X_CENTER);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESPAWN: begin
                if (cnt_q == CW'(RESPAWN_FRAMES - 1)) begin
                    state_d = ALIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    blink_d = cnt_d[BB];
                end
            end
            GAME_OVER: begin
                state_d = GAME_OVER;
            end
            default: state_d = ALIVE;
        endcase
    end

    // State and output registers, cleared asynchronously by Reset
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ALIVE;
            x_q     <= X_W'(X_CENTER);
            lives_q <= 3'(LIVES);
            cnt_q   <= '0;
            cd_q    <= '0;
            prev_q  <= 8'h00;
            fire_q  <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            cd_q    <= cd_d;
            prev_q  <= prev_d;
            fire_q  <= fire_d;
            blink_q <= blink_d;
        end
    end

    assign player_x  = x_q;
    assign player_hw = X_W'(HALF_W);
    assign fire      = fire_q;
    assign lives     = lives_q;
    assign state_o   = state_q;
    assign blink     = blink_q;
    assign game_over = (state_q == GAME_OVER);

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: vector table plus hand-written
// sequences for saturation, cooldown, death/respawn, game over and reset.
module tb_player_ctrl;

    logic       frame_clk;
    logic       Reset;
    logic [7:0] keycode;
    logic       hit;
    logic       bullet_busy;
    logic [9:0] player_x;
    logic [9:0] player_hw;
    logic       fire;
    logic [2:0] lives;
    logic [1:0] state_o;
    logic       blink;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    player_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .hit         (hit),
        .bullet_busy (bullet_busy),
        .player_x    (player_x),
        .player_hw   (player_hw),
        .fire        (fire),
        .lives       (lives),
        .state_o     (state_o),
        .blink       (blink),
        .game_over   (game_over)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [7:0] key;
        logic       hit;
        logic       busy;
        int         x;
        int         fire;
        int         lives;
        int         st;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [7:0] k, input logic h, input logic b);
        keycode     = k;
        hit         = h;
        bullet_busy = b;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        keycode     = 8'h00;
        hit         = 1'b0;
        bullet_busy = 1'b0;
        Reset       = 1'b1;
        @(posedge frame_clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic chk_all(input string nm, input int x, input int f,
                           input int lv, input int st, input int bl);
        chk({nm, " x"}, int'(player_x), x);
        chk({nm, " fire"}, int'(fire), f);
        chk({nm, " lives"}, int'(lives), lv);
        chk({nm, " state"}, int'(state_o), st);
        chk({nm, " blink"}, int'(blink), bl);
        chk({nm, " game_over"}, int'(game_over), (st == 3) ? 1 : 0);
    endtask

    initial begin
        int exp_x;
        int nfire;

        tbl[0] = '{8'h04, 1'b0, 1'b0, 318, 0, 3, 0};
        tbl[1] = '{8'h04, 1'b0, 1'b0, 316, 0, 3, 0};
        tbl[2] = '{8'h07, 1'b0, 1'b0, 318, 0, 3, 0};
        tbl[3] = '{8'h00, 1'b0, 1'b0, 318, 0, 3, 0};
        tbl[4] = '{8'h2C, 1'b0, 1'b0, 318, 1, 3, 0};
        tbl[5] = '{8'h2C, 1'b0, 1'b0, 318, 0, 3, 0};
        tbl[6] = '{8'h00, 1'b0, 1'b0, 318, 0, 3, 0};
        tbl[7] = '{8'h2C, 1'b0, 1'b0, 318, 0, 3, 0};
        tbl[8] = '{8'h07, 1'b0, 1'b0, 320, 0, 3, 0};

        keycode     = 8'h00;
        hit         = 1'b0;
        bullet_busy = 1'b0;
        Reset       = 1'b1;
        #2;
        chk_all("reset", 320, 0, 3, 0, 0);
        chk("hw", int'(player_hw), 8);
        do_reset();
        chk_all("post reset", 320, 0, 3, 0, 0);

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].key, tbl[i].hit, tbl[i].busy);
            chk($sformatf("vec%0d x", i), int'(player_x), tbl[i].x);
            chk($sformatf("vec%0d fire", i), int'(fire), tbl[i].fire);
            chk($sformatf("vec%0d lives", i), int'(lives), tbl[i].lives);
            chk($sformatf("vec%0d state", i), int'(state_o), tbl[i].st);
        end

        exp_x = 320;
        for (int i = 0; i < 200; i++) begin
            exp_x = (exp_x - 2 < 8) ? 8 : exp_x - 2;
            step(8'h04, 1'b0, 1'b0);
            chk("left sat", int'(player_x), exp_x);
        end
        for (int i = 0; i < 320; i++) begin
            exp_x = (exp_x + 2 > 631) ? 631 : exp_x + 2;
            step(8'h07, 1'b0, 1'b0);
            chk("right sat", int'(player_x), exp_x);
        end

        nfire = 0;
        for (int i = 0; i < 40; i++) begin
            step(8'h2C, 1'b0, 1'b0);
            nfire += int'(fire);
        end
        chk("held fire pulses", nfire, 1);

        step(8'h00, 1'b0, 1'b0);
        step(8'h2C, 1'b0, 1'b0);
        chk("shot k", int'(fire), 1);
        repeat (4) step(8'h00, 1'b0, 1'b0);
        step(8'h2C, 1'b0, 1'b0);
        chk("cooldown k+5", int'(fire), 0);
        repeat (11) step(8'h00, 1'b0, 1'b0);
        step(8'h2C, 1'b0, 1'b0);
        chk("shot k+17", int'(fire), 1);
        repeat (20) step(8'h00, 1'b0, 1'b0);
        step(8'h2C, 1'b0, 1'b1);
        chk("busy blocks", int'(fire), 0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h2C, 1'b0, 1'b0);
        chk("busy clear", int'(fire), 1);

        do_reset();
        repeat (110) step(8'h04, 1'b0, 1'b0);
        chk("at 100", int'(player_x), 100);
        step(8'h00, 1'b1, 1'b0);
        chk_all("hit", 100, 0, 2, 1, 0);
        for (int i = 1; i < 32; i++) begin
            step((i % 2 == 1) ? 8'h04 : 8'h2C, (i == 10), 1'b0);
            chk_all($sformatf("dying%0d", i), 100, 0, 2, 1, 0);
        end
        step(8'h00, 1'b0, 1'b0);
        chk_all("respawn0", 320, 0, 2, 2, 0);
        for (int j = 1; j < 64; j++) begin
            step((j == 40) ? 8'h2C : 8'h00, (j == 20), 1'b0);
            chk_all($sformatf("respawn%0d", j), 320, (j == 40) ? 1 : 0,
                    2, 2, (j >> 2) & 1);
        end
        step(8'h00, 1'b0, 1'b0);
        chk_all("alive again", 320, 0, 2, 0, 0);

        step(8'h2C, 1'b1, 1'b0);
        chk_all("hit+fire", 320, 0, 1, 1, 0);
        repeat (96) step(8'h00, 1'b0, 1'b0);
        chk_all("alive 3rd", 320, 0, 1, 0, 0);
        step(8'h00, 1'b1, 1'b0);
        chk_all("game over", 320, 0, 0, 3, 0);
        for (int i = 0; i < 10; i++) begin
            step((i % 2 == 0) ? 8'h04 : 8'h2C, (i % 3 == 0), 1'b0);
            chk_all($sformatf("go%0d", i), 320, 0, 0, 3, 0);
        end

        do_reset();
        chk_all("reset from go", 320, 0, 3, 0, 0);
        step(8'h04, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        step(8'h2C, 1'b0, 1'b0);
        chk("pre shot", int'(fire), 1);
        step(8'h00, 1'b1, 1'b0);
        chk_all("pre dying", 316, 0, 2, 1, 0);
        step(8'h00, 1'b0, 1'b0);
        #3;
        Reset = 1'b1;
        #1;
        chk_all("async reset", 320, 0, 3, 0, 0);
        #2;
        Reset = 1'b0;
        step(8'h00, 1'b0, 1'b0);
        step(8'h2C, 1'b0, 1'b0);
        chk("fire after reset", int'(fire), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
